alu_arbiter: RTL and testbench

- Shares one instance of the team's 16-bit combinational `alu` between two independent requesters, for example the execute stage and an address/branch helper.
- Each requester has a valid/ready request channel (op, operands) and a valid/ready response channel.
- The block arbitrates round-robin, registers the granted operation, evaluates it on the shared ALU, and returns the result in a per-requester response register.
- At most one operation is outstanding per requester.

---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: operation encoding and request payload.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLL = 3'd2,
    ALU_SRL = 3'd3,
    ALU_SRA = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_AND = 3'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t             op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared 16-bit ALU: arbitrate, issue one
// registered operation per cycle, and return each result in a per-requester slot.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  alu_op_t           req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  alu_op_t           req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready,
  output logic              busy
);

  logic                elig0_c, elig1_c;
  logic                grant0_c, grant1_c, hs_c;
  logic [SHAMT_W-1:0]  shamt_c;
  logic signed [DATA_W-1:0] sra_c;
  logic [DATA_W-1:0]   alu_result_c;

  logic                issue_valid_q, issue_valid_d;
  logic                issue_id_q, issue_id_d;
  alu_req_t            issue_q, issue_d;
  logic                last_grant_q, last_grant_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0]   rsp1_data_q, rsp1_data_d;

  // A requester is eligible only when nothing of its own is in flight or held.
  always_comb begin
    elig0_c  = req0_valid & ~rsp0_valid_q & ~(issue_valid_q & ~issue_id_q);
    elig1_c  = req1_valid & ~rsp1_valid_q & ~(issue_valid_q &  issue_id_q);
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (elig0_c && elig1_c) begin
      if (RR_EN && !last_grant_q) grant1_c = 1'b1;
      else                        grant0_c = 1'b1;
    end else begin
      grant0_c = elig0_c;
      grant1_c = elig1_c;
    end
    hs_c = grant0_c | grant1_c;
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  // Shared ALU; shift amounts of 16..31 saturate to zero / sign fill.
  always_comb begin
    shamt_c      = issue_q.b[SHAMT_W-1:0];
    sra_c        = $signed(issue_q.a) >>> shamt_c[SHAMT_W-2:0];
    alu_result_c = '0;
    case (issue_q.op)
      ALU_ADD: alu_result_c = issue_q.a + issue_q.b;
      ALU_SUB: alu_result_c = issue_q.a - issue_q.b;
      ALU_SLL: alu_result_c = shamt_c[SHAMT_W-1] ? '0 : issue_q.a << shamt_c[SHAMT_W-2:0];
      ALU_SRL: alu_result_c = shamt_c[SHAMT_W-1] ? '0 : issue_q.a >> shamt_c[SHAMT_W-2:0];
      ALU_SRA: alu_result_c = shamt_c[SHAMT_W-1] ? {DATA_W{issue_q.a[DATA_W-1]}}
                                                 : DATA_W'(unsigned'(sra_c));
      ALU_XOR: alu_result_c = issue_q.a ^ issue_q.b;
      ALU_OR:  alu_result_c = issue_q.a | issue_q.b;
      ALU_AND: alu_result_c = issue_q.a & issue_q.b;
      default: alu_result_c = '0;
    endcase
  end

  always_comb begin
    issue_valid_d = hs_c;
    issue_id_d    = issue_id_q;
    issue_d       = issue_q;
    last_grant_d  = last_grant_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp0_data_d   = rsp0_data_q;
    rsp1_data_d   = rsp1_data_q;

    if (hs_c) begin
      issue_id_d   = grant1_c;
      last_grant_d = grant1_c;
      issue_d      = grant1_c ? '{op: req1_op, a: req1_a, b: req1_b}
                              : '{op: req0_op, a: req0_a, b: req0_b};
    end

    // Consume and fill never target the same slot in one cycle.
    if (rsp0_valid_q && rsp0_ready) rsp0_valid_d = 1'b0;
    if (rsp1_valid_q && rsp1_ready) rsp1_valid_d = 1'b0;
    if (issue_valid_q && !issue_id_q) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_result_c;
    end
    if (issue_valid_q && issue_id_q) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_result_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= 1'b0;
      issue_q       <= '0;
      last_grant_q  <= 1'b1;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_data_q   <= '0;
      rsp1_data_q   <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      issue_q       <= issue_d;
      last_grant_q  <= last_grant_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_data_q   <= rsp0_data_d;
      rsp1_data_q   <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = issue_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream; a transaction-level model predicts handshakes and results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  alu_op_t     req0_op = ALU_ADD, req1_op = ALU_ADD;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  // Index k: 0 = round-robin instance, 1 = fixed-priority instance.
  logic [1:0]       rdy0, rdy1, rv0, rv1, bsy;
  logic [1:0][15:0] rd0, rd1;

  int checks = 0;
  int errors = 0;
  int c0 [2];
  int c1 [2];

  logic [15:0] exp_q [4][$];
  bit          m_occ  [2][2];
  int          m_age  [2][2];
  bit          m_last [2];

  always #5 clock = ~clock;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_arbiter #(.RR_EN(k == 0)) u_dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(rdy0[k]), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .rsp0_valid(rv0[k]), .rsp0_data(rd0[k]), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(rdy1[k]), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp1_valid(rv1[k]), .rsp1_data(rd1[k]), .rsp1_ready(rsp1_ready),
      .busy(bsy[k])
    );
  end

  task automatic chk1(input string nm, input bit act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%04h expected=%04h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU written with native operators on the masked shift amount.
  function automatic logic [15:0] ref_alu(input alu_op_t op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned        sh = 32'(b & 16'h001F);
    logic signed [15:0] sa = a;
    case (op)
      ALU_ADD: return 16'(32'(a) + 32'(b));
      ALU_SUB: return 16'(32'(a) - 32'(b));
      ALU_SLL: return a << sh;
      ALU_SRL: return a >> sh;
      ALU_SRA: return 16'(unsigned'(sa >>> sh));
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // Transaction model: a requester is occupied from its handshake until its
  // response is consumed; the response appears two edges after the handshake.
  always @(negedge clock) begin
    bit erv0, erv1, ebusy, e0, e1, g0, g1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_occ[k][0] = 1'b0; m_occ[k][1] = 1'b0;
        m_age[k][0] = 0;    m_age[k][1] = 0;
        m_last[k]   = 1'b1;
        exp_q[2*k].delete();
        exp_q[2*k+1].delete();
      end else begin
        erv0  = m_occ[k][0] && m_age[k][0] >= 2;
        erv1  = m_occ[k][1] && m_age[k][1] >= 2;
        ebusy = (m_occ[k][0] && m_age[k][0] == 1) || (m_occ[k][1] && m_age[k][1] == 1);
        e0    = req0_valid && !m_occ[k][0];
        e1    = req1_valid && !m_occ[k][1];
        g0    = e0 && (!e1 || k == 1 || m_last[k]);
        g1    = e1 && !g0;
        chk1($sformatf("req0_ready[%0d]", k), rdy0[k], g0);
        chk1($sformatf("req1_ready[%0d]", k), rdy1[k], g1);
        chk1($sformatf("rsp0_valid[%0d]", k), rv0[k], erv0);
        chk1($sformatf("rsp1_valid[%0d]", k), rv1[k], erv1);
        chk1($sformatf("busy[%0d]", k), bsy[k], ebusy);
        if (m_occ[k][0]) begin
          if (erv0 && rsp0_ready) m_occ[k][0] = 1'b0;
          else                    m_age[k][0]++;
        end
        if (m_occ[k][1]) begin
          if (erv1 && rsp1_ready) m_occ[k][1] = 1'b0;
          else                    m_age[k][1]++;
        end
        if (g0) begin
          m_occ[k][0] = 1'b1; m_age[k][0] = 1; m_last[k] = 1'b0;
          exp_q[2*k].push_back(ref_alu(req0_op, req0_a, req0_b));
        end
        if (g1) begin
          m_occ[k][1] = 1'b1; m_age[k][1] = 1; m_last[k] = 1'b1;
          exp_q[2*k+1].push_back(ref_alu(req1_op, req1_a, req1_b));
        end
      end
    end
  end

  // Response monitor: every presented result must match the oldest expectation.
  always @(negedge clock) begin
    logic        v, r;
    logic [15:0] d;
    int          idx;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 2; i++) begin
          v   = (i == 0) ? rv0[k] : rv1[k];
          d   = (i == 0) ? rd0[k] : rd1[k];
          r   = (i == 0) ? rsp0_ready : rsp1_ready;
          idx = 2 * k + i;
          if (v) begin
            if (exp_q[idx].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_rsp inst=%0d req=%0d actual=%04h expected=none t=%0t",
                       k, i, d, $time);
            end else begin
              chk16($sformatf("rsp_data inst=%0d req=%0d", k, i), d, exp_q[idx][0]);
              if (r) void'(exp_q[idx].pop_front());
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set0(input bit v, input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input bit v, input alu_op_t op, input logic [15:0] a, input logic [15:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  function automatic alu_op_t rnd_op();
    return alu_op_t'(3'($urandom_range(0, 7)));
  endfunction

  // Both requesters valid on the first cycle after reset: req0 first, req1 next.
  task automatic pair_test(input string nm,
                           input alu_op_t op0, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] e0,
                           input alu_op_t op1, input logic [15:0] a1, input logic [15:0] b1,
                           input logic [15:0] e1);
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, op0, a0, b0);
    set1(1'b1, op1, a1, b1);
    @(negedge clock);
    for (int k = 0; k < 2; k++) chk1($sformatf("%s_first_grant0[%0d]", nm, k), rdy0[k], 1'b1);
    step();
    @(negedge clock);
    for (int k = 0; k < 2; k++) chk1($sformatf("%s_second_grant1[%0d]", nm, k), rdy1[k], 1'b1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    chk1({nm, "_rsp0_valid"}, rv0[0], 1'b1);
    chk16({nm, "_rsp0_data"}, rd0[0], e0);
    step();
    @(negedge clock);
    chk1({nm, "_rsp1_valid"}, rv1[0], 1'b1);
    chk16({nm, "_rsp1_data"}, rd1[0], e1);
    step();
    step();
  endtask

  initial begin
    do_reset();

    // Single request, also covering post-reset output values.
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set0(1'b1, ALU_ADD, 16'd3, 16'd4);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("reset_rsp0_valid[%0d]", k), rv0[k], 1'b0);
      chk1($sformatf("reset_rsp1_valid[%0d]", k), rv1[k], 1'b0);
      chk16($sformatf("reset_rsp0_data[%0d]", k), rd0[k], 16'h0000);
      chk16($sformatf("reset_rsp1_data[%0d]", k), rd1[k], 16'h0000);
      chk1($sformatf("reset_busy[%0d]", k), bsy[k], 1'b0);
    end
    chk1("single_ready_c", rdy0[0], 1'b1);
    step();
    @(negedge clock);
    chk1("single_busy_c1", bsy[0], 1'b1);
    chk1("single_rsp_c1", rv0[0], 1'b0);
    step();
    @(negedge clock);
    chk1("single_rsp_c2", rv0[0], 1'b1);
    chk16("single_data_c2", rd0[0], 16'h0007);
    chk1("single_busy_c2", bsy[0], 1'b0);
    step();
    req0_valid = 1'b0;
    step();
    step();

    pair_test("simul", ALU_SUB, 16'd5, 16'd7, 16'hFFFE, ALU_SRA, 16'h8000, 16'd4, 16'hF800);
    pair_test("shift", ALU_SLL, 16'h0001, 16'h0021, 16'h0002, ALU_SRL, 16'hFFFF, 16'd16, 16'h0000);

    // Back-pressure on requester 0 while requester 1 keeps working.
    do_reset();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    set0(1'b1, ALU_OR, 16'h00F0, 16'h000F);
    step();
    step();
    for (int j = 0; j < 6; j++) begin
      set1(1'b1, (j % 2 == 0) ? ALU_XOR : ALU_OR, 16'($urandom), 16'($urandom));
      req0_a = 16'($urandom);
      req0_b = 16'($urandom);
      @(negedge clock);
      chk1("bp_ready0_low", rdy0[0], 1'b0);
      chk1("bp_rsp0_held", rv0[0], 1'b1);
      chk16("bp_rsp0_stable", rd0[0], 16'h00FF);
      step();
    end
    rsp0_ready = 1'b1;
    req1_valid = 1'b0;
    @(negedge clock);
    chk1("bp_no_same_cycle_grant", rdy0[0], 1'b0);
    step();
    rsp0_ready = 1'b0;
    @(negedge clock);
    chk1("bp_grant_after_release", rdy0[0], 1'b1);
    step();
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    repeat (4) step();

    // Reset one cycle after a req1 handshake discards that operation.
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set1(1'b1, ALU_XOR, 16'h1234, 16'h00FF);
    @(negedge clock);
    chk1("mid_req1_grant", rdy1[0], 1'b1);
    step();
    req1_valid = 1'b0;
    reset      = 1'b1;
    step();
    reset = 1'b0;
    set0(1'b1, ALU_ADD, 16'h0010, 16'h0020);
    set1(1'b1, ALU_AND, 16'h0F0F, 16'h00FF);
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("mid_rsp1_valid[%0d]", k), rv1[k], 1'b0);
      chk16($sformatf("mid_rsp1_data[%0d]", k), rd1[k], 16'h0000);
      chk16($sformatf("mid_rsp0_data[%0d]", k), rd0[k], 16'h0000);
      chk1($sformatf("mid_busy[%0d]", k), bsy[k], 1'b0);
      chk1($sformatf("mid_tie_grant0[%0d]", k), rdy0[k], 1'b1);
      chk1($sformatf("mid_tie_not1[%0d]", k), rdy1[k], 1'b0);
    end
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;
    repeat (4) step();

    // Saturation: both always valid, responses always accepted.
    do_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c0[k] = 0;
      c1[k] = 0;
    end
    for (int j = 0; j < 30; j++) begin
      set0(1'b1, rnd_op(), 16'($urandom), 16'($urandom_range(0, 31)));
      set1(1'b1, rnd_op(), 16'($urandom), 16'($urandom_range(0, 31)));
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        c0[k] += int'(rdy0[k]);
        c1[k] += int'(rdy1[k]);
      end
      step();
    end
    chk1("fair_rr_balance", (c0[0] - c1[0] <= 1) && (c1[0] - c0[0] <= 1), 1'b1);
    chk1("fair_rr_total", (c0[0] + c1[0]) == 20, 1'b1);
    chk1("fair_fp_total", (c0[1] + c1[1]) == 20, 1'b1);
    chk1("fair_fp_req0_not_behind", c0[1] >= c1[1], 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) step();

    // Random traffic with random response back-pressure.
    for (int j = 0; j < 400; j++) begin
      set0($urandom_range(0, 3) != 0, rnd_op(), 16'($urandom),
           ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40)));
      set1($urandom_range(0, 3) != 0, rnd_op(), 16'($urandom),
           ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40)));
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (6) step();
    @(negedge clock);
    for (int q = 0; q < 4; q++)
      chk1($sformatf("drain_empty[%0d]", q), exp_q[q].size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
